// File: rtl/fpu_div_seq.sv
// Sequential binary32 divider: special operands resolve in one cycle, normal
// operands go through a 27-step restoring divide followed by one normalise/round
// cycle. Results and RISC-V fflags are presented with a one-cycle done pulse.
module fpu_div_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      flags
);

  // state | meaning
  // IDLE  | waiting for start; special operands are resolved here
  // CALC  | one restoring-division quotient bit per cycle
  // NORM  | normalise, round, range-check and register the result
  typedef enum logic [1:0] {IDLE, CALC, NORM} state_t;

  state_t             state, state_nxt;
  logic [4:0]         cnt;
  logic [23:0]        rem;
  logic [23:0]        mb;
  logic [26:0]        q;
  logic signed [9:0]  exp_q;
  logic               sign;
  logic               dvd_lsb;

  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan, special;
  logic [31:0] spec_res;
  logic [4:0]  spec_flags;

  // Operand classification; denormals are folded into zero.
  always_comb begin
    a_zero  = (a[30:23] == 8'h00);
    b_zero  = (b[30:23] == 8'h00);
    a_inf   = (a[30:23] == 8'hFF) && (a[22:0] == 23'h0);
    b_inf   = (b[30:23] == 8'hFF) && (b[22:0] == 23'h0);
    a_nan   = (a[30:23] == 8'hFF) && (a[22:0] != 23'h0);
    b_nan   = (b[30:23] == 8'hFF) && (b[22:0] != 23'h0);
    a_snan  = a_nan && !a[22];
    b_snan  = b_nan && !b[22];
    special = a_zero | b_zero | a_inf | b_inf | a_nan | b_nan;
  end

  // Result and flags for operands that bypass the divider.
  always_comb begin
    spec_res   = {a[31] ^ b[31], 31'h0};
    spec_flags = 5'b00000;
    if (a_nan || b_nan) begin
      spec_res   = 32'h7FC00000;
      spec_flags = (a_snan || b_snan) ? 5'b10000 : 5'b00000;
    end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_res   = 32'h7FC00000;
      spec_flags = 5'b10000;
    end else if (a_inf) begin
      spec_res   = {a[31] ^ b[31], 8'hFF, 23'h0};
    end else if (b_zero) begin
      spec_res   = {a[31] ^ b[31], 8'hFF, 23'h0};
      spec_flags = 5'b01000;
    end
  end

  logic [24:0] rem_sh;
  logic [23:0] rem_diff;
  logic        q_bit;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  // Only the first step shifts in a real bit (ma[0]); the rest are zeros.
  always_comb begin
    rem_sh   = {rem, (cnt == 5'd26) ? dvd_lsb : 1'b0};
    q_bit    = (rem_sh >= {1'b0, mb});
    rem_diff = rem_sh[23:0] - mb;
  end

  logic [22:0]       n_frac;
  logic              n_g, n_s, inc, nx;
  logic signed [9:0] n_exp, f_exp;
  logic [23:0]       r_frac;
  logic [31:0]       norm_res;
  logic [4:0]        norm_flags;

  // Normalise the quotient, round to nearest even and range-check.
  // The leading one is implicit, so a carry out of the fraction is the
  // 0xFFFFFF+1 mantissa overflow.
  always_comb begin
    if (q[26]) begin
      n_frac = q[25:3];
      n_g    = q[2];
      n_s    = (|q[1:0]) | (|rem);
      n_exp  = exp_q;
    end else begin
      n_frac = q[24:2];
      n_g    = q[1];
      n_s    = q[0] | (|rem);
      n_exp  = exp_q - 10'sd1;
    end
    inc    = n_g & (n_s | n_frac[0]);
    nx     = n_g | n_s;
    r_frac = {1'b0, n_frac} + {23'h0, inc};
    f_exp  = r_frac[23] ? (n_exp + 10'sd1) : n_exp;
    if (f_exp >= 10'sd255) begin
      norm_res   = {sign, 8'hFF, 23'h0};
      norm_flags = 5'b00101;
    end else if (f_exp <= 10'sd0) begin
      norm_res   = {sign, 31'h0};
      norm_flags = 5'b00011;
    end else begin
      norm_res   = {sign, f_exp[7:0], r_frac[22:0]};
      norm_flags = {4'b0000, nx};
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic and busy.
  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    case (state)
      IDLE:    if (start && !special) state_nxt = CALC;
      CALC:    if (cnt == 5'd0) state_nxt = NORM;
      NORM:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath registers: operand capture, divide steps and result write-back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= 5'd0;
      rem     <= 24'h0;
      mb      <= 24'h0;
      q       <= 27'h0;
      exp_q   <= 10'sd0;
      sign    <= 1'b0;
      dvd_lsb <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      flags   <= 5'b00000;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (special) begin
              result <= spec_res;
              flags  <= spec_flags;
              done   <= 1'b1;
            end else begin
              rem     <= {2'b01, a[22:1]};
              dvd_lsb <= a[0];
              mb      <= {1'b1, b[22:0]};
              exp_q   <= $signed({2'b00, a[30:23]}) - $signed({2'b00, b[30:23]}) + 10'sd127;
              sign    <= a[31] ^ b[31];
              q       <= 27'h0;
              cnt     <= 5'd26;
            end
          end
        end
        CALC: begin
          rem <= q_bit ? rem_diff : rem_sh[23:0];
          q   <= {q[25:0], q_bit};
          cnt <= cnt - 5'd1;
        end
        NORM: begin
          result <= norm_res;
          flags  <= norm_flags;
          done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_div_seq.sv
// Bench for fpu_div_seq: fixed vectors, randomized operands against an
// integer-arithmetic reference, handshake and reset sequences.
module tb_fpu_div_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a = 32'h0;
  logic [31:0] b = 32'h0;
  logic        busy, done;
  logic [31:0] result;
  logic [4:0]  flags;

  int checks = 0;
  int errors = 0;

  fpu_div_seq #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .flags(flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [4:0]  flg;
    int          lat;
    int          bsy;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp_v);
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp_v);
    end
  endtask

  // Reference: exact integer quotient/remainder, then the rounding rules.
  function automatic void ref_div(input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output logic [4:0] f,
                                  output int lat);
    int     ex, ey, e;
    bit     xz, yz, xi, yi, xn, yn, xs, ys, s, g, st;
    longint num, den, qq, rm, mant;
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    s  = x[31] ^ y[31];
    xz = (ex == 0);  yz = (ey == 0);
    xi = (ex == 255) && (x[22:0] == 0);
    yi = (ey == 255) && (y[22:0] == 0);
    xn = (ex == 255) && (x[22:0] != 0);
    yn = (ey == 255) && (y[22:0] != 0);
    xs = xn && !x[22];
    ys = yn && !y[22];
    f  = 5'b0;
    lat = 0;
    if (xn || yn) begin
      r = 32'h7FC00000; f = (xs || ys) ? 5'h10 : 5'h00;
    end else if ((xz && yz) || (xi && yi)) begin
      r = 32'h7FC00000; f = 5'h10;
    end else if (xi) begin
      r = {s, 8'hFF, 23'h0};
    end else if (yz) begin
      r = {s, 8'hFF, 23'h0}; f = 5'h08;
    end else if (yi || xz) begin
      r = {s, 31'h0};
    end else begin
      lat = 28;
      num = (longint'(8388608) + longint'(x[22:0])) * 64'd67108864;
      den = longint'(8388608) + longint'(y[22:0]);
      qq  = num / den;
      rm  = num % den;
      e   = ex - ey + 127;
      if (qq >= 64'd67108864) begin
        mant = qq / 8;  g = ((qq / 4) % 2) == 1; st = (qq % 4 != 0) || (rm != 0);
      end else begin
        mant = qq / 4;  g = ((qq / 2) % 2) == 1; st = (qq % 2 != 0) || (rm != 0);
        e = e - 1;
      end
      if (g && (st || (mant % 2 == 1))) mant = mant + 1;
      if (mant == 64'd16777216) begin mant = 64'd8388608; e = e + 1; end
      if (e >= 255) begin
        r = {s, 8'hFF, 23'h0}; f = 5'h05;
      end else if (e <= 0) begin
        r = {s, 31'h0}; f = 5'h03;
      end else begin
        r = {s, 8'(e), 23'(mant % 64'd8388608)};
        f = {4'b0, g | st};
      end
    end
  endfunction

  function automatic logic [31:0] rnd_fp();
    logic [31:0] v;
    int sel;
    v   = $urandom;
    sel = $urandom_range(0, 19);
    case (sel)
      0: v[30:23] = 8'h00;
      1: begin v[30:23] = 8'hFF; v[22:0] = 23'h0; end
      2: begin v[30:23] = 8'hFF; if (v[22:0] == 23'h0) v[0] = 1'b1; end
      3: v[30:23] = 8'($urandom_range(1, 12));
      4: v[30:23] = 8'($urandom_range(243, 254));
      default: v[30:23] = 8'($urandom_range(1, 254));
    endcase
    return v;
  endfunction

  // Called at a negedge; returns at the negedge following the start edge.
  task automatic launch(input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
  endtask

  // e = index of the edge after which done is first seen (start edge = 0).
  task automatic wait_done(output int e, output int bc);
    e = 0; bc = 0;
    while (!done && e < 100) begin
      if (busy) bc++;
      @(negedge clk);
      e++;
    end
  endtask

  task automatic run_op(input string nm, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] er, input logic [4:0] ef,
                        input int elat, input int ebusy);
    int e, bc;
    launch(x, y);
    wait_done(e, bc);
    chk({nm, " result"}, result, er);
    chk({nm, " flags"}, {27'h0, flags}, {27'h0, ef});
    chk({nm, " latency"}, e, elat);
    chk({nm, " busy_cycles"}, bc, ebusy);
    chk({nm, " busy_at_done"}, {31'h0, busy}, 32'h0);
    @(negedge clk);
    chk({nm, " done_one_cycle"}, {31'h0, done}, 32'h0);
  endtask

  initial begin
    vec_t vecs[14];
    logic [31:0] rr;
    logic [4:0]  rf;
    int rl, e, bc, cnt_done;

    vecs[0]  = '{32'h40C00000, 32'h40000000, 32'h40400000, 5'h00, 28, 28};
    vecs[1]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'h01, 28, 28};
    vecs[2]  = '{32'h3F800000, 32'h00000000, 32'h7F800000, 5'h08, 0, 0};
    vecs[3]  = '{32'h00000000, 32'h00000000, 32'h7FC00000, 5'h10, 0, 0};
    vecs[4]  = '{32'h7F800001, 32'h3F800000, 32'h7FC00000, 5'h10, 0, 0};
    vecs[5]  = '{32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, 5'h05, 28, 28};
    vecs[6]  = '{32'h00800000, 32'h40000000, 32'h00000000, 5'h03, 28, 28};
    vecs[7]  = '{32'hC0C00000, 32'h40000000, 32'hC0400000, 5'h00, 28, 28};
    vecs[8]  = '{32'h7F800000, 32'hFF800000, 32'h7FC00000, 5'h10, 0, 0};
    vecs[9]  = '{32'h7F800000, 32'h40000000, 32'h7F800000, 5'h00, 0, 0};
    vecs[10] = '{32'h40000000, 32'hFF800000, 32'h80000000, 5'h00, 0, 0};
    vecs[11] = '{32'hBF800000, 32'h00000000, 32'hFF800000, 5'h08, 0, 0};
    vecs[12] = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 5'h00, 0, 0};
    vecs[13] = '{32'h00000001, 32'h3F800000, 32'h00000000, 5'h00, 0, 0};

    repeat (3) @(negedge clk);
    chk("reset busy", {31'h0, busy}, 32'h0);
    chk("reset done", {31'h0, done}, 32'h0);
    chk("reset result", result, 32'h0);
    chk("reset flags", {27'h0, flags}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].res,
             vecs[i].flg, vecs[i].lat, vecs[i].bsy);

    for (int i = 0; i < 60; i++) begin
      logic [31:0] x, y;
      x = rnd_fp();
      y = rnd_fp();
      ref_div(x, y, rr, rf, rl);
      run_op($sformatf("rnd%0d %08h/%08h", i, x, y), x, y, rr, rf, rl, rl);
    end

    // start pulses while busy (including the NORM cycle) must be ignored
    launch(32'h40C00000, 32'h40000000);
    e = 0;
    while (!done && e < 100) begin
      if (e == 5 || e == 27) begin
        start = 1'b1; a = 32'h3F800000; b = 32'h40400000;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      e++;
    end
    start = 1'b0;
    chk("ignore_start result", result, 32'h40400000);
    chk("ignore_start flags", {27'h0, flags}, 32'h0);
    chk("ignore_start latency", e, 28);
    cnt_done = 0;
    repeat (35) begin
      @(negedge clk);
      if (done || busy) cnt_done++;
    end
    chk("ignore_start no_followup", cnt_done, 0);

    // start in the done cycle is accepted
    launch(32'h40C00000, 32'h40000000);
    wait_done(e, bc);
    chk("b2b first result", result, 32'h40400000);
    launch(32'h3F800000, 32'h40400000);
    wait_done(e, bc);
    chk("b2b second result", result, 32'h3EAAAAAB);
    chk("b2b second flags", {27'h0, flags}, 32'h01);
    chk("b2b second latency", e, 28);
    @(negedge clk);

    // asynchronous reset mid-divide
    launch(32'h40C00000, 32'h40000000);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset busy", {31'h0, busy}, 32'h0);
    chk("midreset done", {31'h0, done}, 32'h0);
    chk("midreset result", result, 32'h0);
    chk("midreset flags", {27'h0, flags}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cnt_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) cnt_done++;
    end
    chk("midreset no_done", cnt_done, 0);
    run_op("post_reset", 32'h40C00000, 32'h40000000, 32'h40400000, 5'h00, 28, 28);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
